// File: rtl/kexp_multi.sv
// -----------------------------------------------------------------------------
// kexp_multi -- AES-128/192/256 key expansion with a streamed round-key output.
//
// A legal load writes the cipher key words w[0..Nk-1] into an internal word
// store. The remaining words are then generated one per cycle (FIPS-197 key
// schedule). The round keys are streamed 128 bits at a time over a valid/ready
// handshake. The order is forward (rk0..rkNr) or reverse (rkNr..rk0).
//
// Parameters
//   MAX_NK   largest supported key length in 32-bit words (4, 6 or 8)
//   KEY_W    key port width, 32*MAX_NK (derived)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active high
//   key_ld_p  load pulse; samples key, key_len and enc
//   key       cipher key, MSB aligned (word0 = key[KEY_W-1 -: 32])
//   key_len   0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal
//   enc       1 = forward key order, 0 = reverse key order
//   rk_vld    round key valid
//   rk        round key, word0 in bits [127:96]
//   rk_rdy    round key accepted when rk_vld && rk_rdy
//   rk_last   marks the final round key of the stream
//   busy      high while expanding or streaming
//   key_err   one-cycle pulse when a load is rejected
//
// Optional build macro
//   KEXP_EQINV_EN  reverse-order keys rk(1)..rk(Nr-1) are passed through
//                  InvMixColumns (equivalent inverse cipher keys).
// -----------------------------------------------------------------------------
module kexp_multi #(
    parameter int MAX_NK = 8,
    parameter int KEY_W  = 32 * MAX_NK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_ld_p,
    input  logic [KEY_W-1:0] key,
    input  logic [1:0]       key_len,
    input  logic             enc,
    output logic             rk_vld,
    output logic [127:0]     rk,
    input  logic             rk_rdy,
    output logic             rk_last,
    output logic             busy,
    output logic             key_err
);
    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_OUT} state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            2'd0:    return 4'd4;
            2'd1:    return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] b;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        b = gf_mul(r, r);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;       // index of the word being generated
    logic [2:0]     k_q, k_d;           // cnt_q mod Nk
    logic [7:0]     rcon_q, rcon_d;     // Rcon for the next i%Nk==0 word
    logic [1:0]     len_q, len_d;
    logic           enc_q, enc_d;
    logic [3:0]     r_q, r_d;           // round index of the next key to present
    logic [127:0]   rk_q, rk_d;
    logic           rk_vld_q, rk_vld_d;
    logic           rk_last_q, rk_last_d;
    logic           key_err_q, key_err_d;

    logic [31:0]    mem [DEPTH];

    logic [3:0]     ld_nk, cur_nk, cur_nr, end_r;
    logic           ld_legal, ld_ok, expand_done;
    logic [AW-1:0]  last_word, rk_base;
    logic [31:0]    w_prev, w_back, t_word, w_new;
    logic [127:0]   rk_raw, rk_out;

    assign ld_nk       = nk_of(key_len);
    assign ld_legal    = (key_len != 2'd3) && (int'(ld_nk) <= MAX_NK);
    assign ld_ok       = key_ld_p && ld_legal;
    assign cur_nk      = nk_of(len_q);
    assign cur_nr      = cur_nk + 4'd6;
    assign end_r       = enc_q ? cur_nr : 4'd0;
    assign last_word   = AW'({cur_nr, 2'b11});
    assign expand_done = (cnt_q == last_word);
    assign rk_base     = AW'({r_q, 2'b00});

    // Key schedule step for word cnt_q.
    always_comb begin
        w_prev = mem[cnt_q - AW'(1)];
        w_back = mem[cnt_q - AW'(cur_nk)];
        if (k_q == 3'd0)
            t_word = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
        else if (cur_nk == 4'd8 && k_q == 3'd4)
            t_word = sub_word(w_prev);
        else
            t_word = w_prev;
        w_new = w_back ^ t_word;
    end

    assign rk_raw = {mem[rk_base], mem[rk_base + AW'(1)],
                     mem[rk_base + AW'(2)], mem[rk_base + AW'(3)]};

`ifdef KEXP_EQINV_EN
    function automatic logic [31:0] inv_mix(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // The first and last keys of the reverse stream pass through unchanged.
    always_comb begin
        if (!enc_q && r_q != 4'd0 && r_q != cur_nr)
            rk_out = {inv_mix(rk_raw[127:96]), inv_mix(rk_raw[95:64]),
                      inv_mix(rk_raw[63:32]),  inv_mix(rk_raw[31:0])};
        else
            rk_out = rk_raw;
    end
`else
    assign rk_out = rk_raw;
`endif

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // A legal load overrides everything, including an rk_last handshake.
    always_comb begin
        state_d = state_q;
        if (ld_ok) begin
            state_d = S_EXPAND;
        end else begin
            case (state_q)
                S_EXPAND: if (expand_done) state_d = S_OUT;
                S_OUT:    if (rk_vld_q && rk_rdy && rk_last_q) state_d = S_IDLE;
                default:  ;
            endcase
        end
    end

    // NOTE: every signal gets a default at the top so no path infers a latch.
    always_comb begin
        cnt_d     = cnt_q;
        k_d       = k_q;
        rcon_d    = rcon_q;
        len_d     = len_q;
        enc_d     = enc_q;
        r_d       = r_q;
        rk_d      = rk_q;
        rk_vld_d  = rk_vld_q;
        rk_last_d = rk_last_q;
        key_err_d = key_ld_p && !ld_legal;
        busy      = (state_q != S_IDLE);
        if (ld_ok) begin
            cnt_d     = AW'(ld_nk);
            k_d       = '0;
            rcon_d    = 8'h01;
            len_d     = key_len;
            enc_d     = enc;
            r_d       = enc ? 4'd0 : ld_nk + 4'd6;
            rk_vld_d  = 1'b0;
            rk_last_d = 1'b0;
        end else begin
            case (state_q)
                S_EXPAND: begin
                    if (!expand_done) cnt_d = cnt_q + AW'(1);
                    if ({1'b0, k_q} == cur_nk - 4'd1) k_d = '0;
                    else                               k_d = k_q + 3'd1;
                    if (k_q == 3'd0) rcon_d = xtime(rcon_q);
                end
                S_OUT: begin
                    if (rk_vld_q && rk_rdy && rk_last_q) begin
                        rk_vld_d  = 1'b0;
                        rk_last_d = 1'b0;
                    end else if (!rk_vld_q || rk_rdy) begin
                        rk_vld_d  = 1'b1;
                        rk_d      = rk_out;
                        rk_last_d = (r_q == end_r);
                        if (r_q != end_r) r_d = enc_q ? r_q + 4'd1 : r_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= AW'(4);
            k_q       <= '0;
            rcon_q    <= 8'h01;
            len_q     <= 2'd0;
            enc_q     <= 1'b1;
            r_q       <= '0;
            rk_q      <= '0;
            rk_vld_q  <= 1'b0;
            rk_last_q <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            rcon_q    <= rcon_d;
            len_q     <= len_d;
            enc_q     <= enc_d;
            r_q       <= r_d;
            rk_q      <= rk_d;
            rk_vld_q  <= rk_vld_d;
            rk_last_q <= rk_last_d;
            key_err_q <= key_err_d;
        end
    end

    // NOTE: the word store has no reset; every word is written by a load or
    // by expansion before it is read for a round key.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            for (int j = 0; j < MAX_NK; j++)
                if (j < int'(ld_nk)) mem[j] <= key[KEY_W-1-32*j -: 32];
        end else if (state_q == S_EXPAND) begin
            mem[cnt_q] <= w_new;
        end
    end

    assign rk_vld  = rk_vld_q;
    assign rk      = rk_q;
    assign rk_last = rk_last_q;
    assign key_err = key_err_q;

endmodule

// File: tb/tb_kexp_multi.sv
// -----------------------------------------------------------------------------
// tb_kexp_multi -- self-checking bench for kexp_multi.
// Reference: a plain FIPS-197 key schedule over an array, with an S-box table
// built by the multiplicative-generator walk. Directed FIPS vectors plus
// randomized keys, lengths, orders and ready patterns.
// -----------------------------------------------------------------------------
module tb_kexp_multi;
    localparam int MAX_NK = 8;
    localparam int KEY_W  = 32 * MAX_NK;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                     128'h0123456789abcdeffedcba9876543210};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'hdeadbeefcafef00d};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_ld_p;
    logic [KEY_W-1:0] key;
    logic [1:0]       key_len;
    logic             enc;
    logic             rk_vld;
    logic [127:0]     rk;
    logic             rk_rdy;
    logic             rk_last;
    logic             busy;
    logic             key_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox_t [256];
    logic [31:0]  mw [60];
    logic [127:0] got [15];

    kexp_multi #(.MAX_NK(MAX_NK)) dut (
        .clk(clk), .rst(rst), .key_ld_p(key_ld_p), .key(key), .key_len(key_len),
        .enc(enc), .rk_vld(rk_vld), .rk(rk), .rk_rdy(rk_rdy), .rk_last(rk_last),
        .busy(busy), .key_err(key_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk p through powers of 3 while q tracks its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < n; i++) r = xt(r);
        return r;
    endfunction

    task automatic model_expand(input logic [KEY_W-1:0] k, input int nk);
        logic [31:0] t;
        int nr;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) mw[i] = k[KEY_W-1-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = mw[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % 8 == 4)
                t = subw(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

`ifdef KEXP_EQINV_EN
    function automatic logic [31:0] inv_mix_w(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] m9 [4], mb [4], md [4], me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            m9[i] = xt(xt(xt(a[i]))) ^ a[i];
            mb[i] = xt(xt(xt(a[i]))) ^ xt(a[i]) ^ a[i];
            md[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ a[i];
            me[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ xt(a[i]);
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input logic [KEY_W-1:0] k, input logic [1:0] len, input logic e);
        key_ld_p = 1'b1;
        key      = k;
        key_len  = len;
        enc      = e;
        @(posedge clk); #1;
        key_ld_p = 1'b0;
    endtask

    task automatic wait_vld(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!rk_vld && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 128'(n), 128'(exp_lat));
    endtask

    task automatic start(input string name, input logic [KEY_W-1:0] k,
                         input logic [1:0] len, input logic e);
        int nk;
        nk = 4 + 2 * int'(len);
        model_expand(k, nk);
        do_load(k, len, e);
        check({name, " busy after load"}, 128'(busy), 128'(1));
        check({name, " vld after load"}, 128'(rk_vld), 128'(0));
        wait_vld(name, 4 * (nk + 7) - nk + 1);
    endtask

    // Accept the whole stream; optionally load a new key with the final handshake.
    task automatic collect(input string name, input int nk, input logic e, input bit rnd_rdy,
                           input bit reload, input logic [KEY_W-1:0] nkey,
                           input logic [1:0] nlen, input logic nenc);
        int nr, idx, cyc, r;
        logic [127:0] held, ev;
        bit stalled;
        nr = nk + 6;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (idx <= nr && cyc < 400) begin
            if (!rk_vld) begin
                check($sformatf("%s vld at key %0d", name, idx), 128'(rk_vld), 128'(1));
                break;
            end
            if (stalled) check($sformatf("%s stall hold", name), rk, held);
            rk_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_rdy) begin
                r  = e ? idx : nr - idx;
                ev = exp_rk(r);
`ifdef KEXP_EQINV_EN
                if (!e && r != 0 && r != nr)
                    ev = {inv_mix_w(ev[127:96]), inv_mix_w(ev[95:64]),
                          inv_mix_w(ev[63:32]), inv_mix_w(ev[31:0])};
`endif
                check($sformatf("%s rk%0d", name, r), rk, ev);
                check($sformatf("%s last at rk%0d", name, r), 128'(rk_last), 128'(idx == nr));
                got[idx] = rk;
                if (reload && idx == nr) begin
                    key_ld_p = 1'b1;
                    key      = nkey;
                    key_len  = nlen;
                    enc      = nenc;
                end
                idx++;
                stalled = 1'b0;
            end else begin
                held    = rk;
                stalled = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rk_rdy   = 1'b0;
        key_ld_p = 1'b0;
        check({name, " key count"}, 128'(idx), 128'(nr + 1));
        check({name, " vld after last"}, 128'(rk_vld), 128'(0));
        check({name, " busy after last"}, 128'(busy), 128'(reload));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [KEY_W-1:0] rkey;
        logic [1:0]       rlen;
        logic             renc;

        build_sbox();
        rst      = 1'b1;
        key_ld_p = 1'b0;
        key      = '0;
        key_len  = 2'd0;
        enc      = 1'b0;
        rk_rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rk_vld", 128'(rk_vld), 128'(0));
        check("reset rk", rk, 128'(0));
        check("reset rk_last", 128'(rk_last), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset key_err", 128'(key_err), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle busy", 128'(busy), 128'(0));

        // Illegal load while idle.
        do_load(K128, 2'd3, 1'b1);
        key_len = 2'd0;
        check("idle illegal key_err", 128'(key_err), 128'(1));
        check("idle illegal busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        check("idle key_err one cycle", 128'(key_err), 128'(0));

        // AES-128 forward, FIPS-197 vector.
        start("t1", K128, 2'd0, 1'b1);
        collect("t1", 4, 1'b1, 1'b0, 1'b0, '0, 2'd0, 1'b0);
        check("t1 rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("t1 rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-128 reverse.
        start("t2", K128, 2'd0, 1'b0);
        collect("t2", 4, 1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b0);
        check("t2 first key", got[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("t2 last key", got[10], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // AES-192 forward.
        start("t3", K192, 2'd1, 1'b1);
        collect("t3", 6, 1'b1, 1'b0, 1'b0, '0, 2'd0, 1'b0);
        check("t3 rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

        // AES-256 forward with random back-pressure.
        start("t4", K256, 2'd2, 1'b1);
        collect("t4", 8, 1'b1, 1'b1, 1'b0, '0, 2'd0, 1'b0);
        check("t4 rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Load in the same cycle as the rk_last handshake: the load wins.
        start("t5a", K128, 2'd0, 1'b1);
        collect("t5a", 4, 1'b1, 1'b0, 1'b1, K192, 2'd1, 1'b0);
        model_expand(K192, 6);
        wait_vld("t5b", 47);
        collect("t5b", 6, 1'b0, 1'b1, 1'b0, '0, 2'd0, 1'b0);

        // Abort mid-stream with a new key, then an illegal load mid-stream.
        start("t6a", K256, 2'd2, 1'b1);
        rk_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rk_rdy = 1'b0;
        model_expand(K128, 4);
        do_load(K128, 2'd0, 1'b1);
        check("t6 abort vld drop", 128'(rk_vld), 128'(0));
        check("t6 abort busy", 128'(busy), 128'(1));
        wait_vld("t6 restart", 41);
        check("t6 restart rk0", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        do_load(K256, 2'd3, 1'b0);
        key_len = 2'd0;
        check("t6 illegal key_err", 128'(key_err), 128'(1));
        check("t6 illegal vld held", 128'(rk_vld), 128'(1));
        check("t6 illegal rk held", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        @(posedge clk); #1;
        check("t6 key_err one cycle", 128'(key_err), 128'(0));
        collect("t6", 4, 1'b1, 1'b0, 1'b0, '0, 2'd0, 1'b0);

        // Asynchronous reset during expansion.
        do_load(K192, 2'd1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("t7 busy mid-expand", 128'(busy), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("t7 async busy", 128'(busy), 128'(0));
        check("t7 async rk", rk, 128'(0));
        check("t7 async rk_vld", 128'(rk_vld), 128'(0));
        check("t7 async rk_last", 128'(rk_last), 128'(0));
        check("t7 async key_err", 128'(key_err), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t7 idle after reset", 128'(busy), 128'(0));

        // Randomized keys, lengths, orders and back-pressure.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 8; i++) rkey[32*i +: 32] = $urandom();
            rlen = 2'($urandom_range(0, 2));
            renc = 1'($urandom_range(0, 1));
            start($sformatf("rnd%0d", n), rkey, rlen, renc);
            collect($sformatf("rnd%0d", n), 4 + 2 * int'(rlen), renc, 1'b1, 1'b0, '0, 2'd0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
